// File: rtl/rx_frame_if.sv
// Byte-in / frame-out bus of the UART frame assembler.
// slave: assembler side, master: byte source plus frame consumer.
interface rx_frame_if #(
    parameter int N_WORDS = 64
);
    logic [7:0]             rx_data_i;
    logic                   rx_valid_i;
    logic [16*N_WORDS-1:0]  frame_o;
    logic                   frame_valid_o;
    logic                   frame_ready_i;
    logic                   busy_o;
    logic                   err_timeout_o;
    logic                   err_overrun_o;

    modport master (
        output rx_data_i, rx_valid_i, frame_ready_i,
        input  frame_o, frame_valid_o, busy_o, err_timeout_o, err_overrun_o
    );

    modport slave (
        input  rx_data_i, rx_valid_i, frame_ready_i,
        output frame_o, frame_valid_o, busy_o, err_timeout_o, err_overrun_o
    );
endinterface

// File: rtl/rx_frame_assembler.sv
// Packs UART bytes little-endian into a frame of N_WORDS 16-bit words and
// presents it with a valid/ready handshake. A partial frame is discarded
// after TIMEOUT_CLKS idle clocks; bytes arriving while a full frame waits
// for the consumer are dropped and flagged.
module rx_frame_assembler #(
    parameter int N_WORDS      = 64,
    parameter int TIMEOUT_CLKS = 2000
) (
    input  logic        clk,
    input  logic        rst_n,
    rx_frame_if.slave   bus
);
    localparam int NB    = 2 * N_WORDS;
    localparam int IDX_W = (NB > 1) ? $clog2(NB) : 1;
    localparam int CNT_W = $clog2(TIMEOUT_CLKS + 1);
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NB - 1);
    localparam logic [CNT_W-1:0] LIMIT_CNT = CNT_W'(TIMEOUT_CLKS - 1);

    typedef enum logic [1:0] {IDLE, COLLECT, FULL} state_t;

    state_t                state;
    logic [IDX_W-1:0]      idx;
    logic [CNT_W-1:0]      idle_cnt;
    logic [16*N_WORDS-1:0] frame;
    logic                  frame_valid;
    logic                  busy;
    logic                  err_timeout;
    logic                  err_overrun;

    // Frame assembly FSM; every output is a register updated here.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            idx         <= '0;
            idle_cnt    <= '0;
            frame       <= '0;
            frame_valid <= 1'b0;
            busy        <= 1'b0;
            err_timeout <= 1'b0;
            err_overrun <= 1'b0;
        end else begin
            err_timeout <= 1'b0;
            err_overrun <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.rx_valid_i) begin
                        frame[7:0] <= bus.rx_data_i;
                        idx        <= IDX_W'(1);
                        idle_cnt   <= '0;
                        busy       <= 1'b1;
                        state      <= COLLECT;
                    end
                end
                COLLECT: begin
                    // A strobe on the limit cycle still counts as a byte.
                    if (bus.rx_valid_i) begin
                        frame[{idx, 3'b000} +: 8] <= bus.rx_data_i;
                        idle_cnt <= '0;
                        if (idx == LAST_IDX) begin
                            idx         <= '0;
                            frame_valid <= 1'b1;
                            state       <= FULL;
                        end else begin
                            idx <= idx + 1'b1;
                        end
                    end else if (idle_cnt == LIMIT_CNT) begin
                        // Stale bytes stay in frame; only the index resets.
                        idx         <= '0;
                        idle_cnt    <= '0;
                        busy        <= 1'b0;
                        err_timeout <= 1'b1;
                        state       <= IDLE;
                    end else begin
                        idle_cnt <= idle_cnt + 1'b1;
                    end
                end
                FULL: begin
                    if (bus.frame_ready_i) begin
                        frame_valid <= 1'b0;
                        idle_cnt    <= '0;
                        // A byte landing on the handshake cycle opens the next frame.
                        if (bus.rx_valid_i) begin
                            frame[7:0] <= bus.rx_data_i;
                            idx        <= IDX_W'(1);
                            state      <= COLLECT;
                        end else begin
                            idx   <= '0;
                            busy  <= 1'b0;
                            state <= IDLE;
                        end
                    end else if (bus.rx_valid_i) begin
                        err_overrun <= 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    idx   <= '0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.frame_o       = frame;
    assign bus.frame_valid_o = frame_valid;
    assign bus.busy_o        = busy;
    assign bus.err_timeout_o = err_timeout;
    assign bus.err_overrun_o = err_overrun;
endmodule

// File: tb/tb_rx_frame_assembler.sv
// Directed bench for rx_frame_assembler: expected frames are queued as bytes
// are sent and popped when the assembler raises frame_valid_o.
module tb_rx_frame_assembler;
    localparam int N_WORDS      = 64;
    localparam int TIMEOUT_CLKS = 2000;
    localparam int NB           = 2 * N_WORDS;
    localparam int FW           = 16 * N_WORDS;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    rx_frame_if #(.N_WORDS(N_WORDS)) bus ();

    rx_frame_assembler #(.N_WORDS(N_WORDS), .TIMEOUT_CLKS(TIMEOUT_CLKS)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int checks = 0;
    int failures = 0;
    int ov_cnt = 0;
    int to_cnt = 0;
    logic [FW-1:0] exp_q[$];

    // Error pulses are counted mid-cycle, away from the active edge.
    always @(negedge clk) begin
        if (bus.err_overrun_o === 1'b1) ov_cnt++;
        if (bus.err_timeout_o === 1'b1) to_cnt++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [FW-1:0] obs, input logic [FW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        repeat (gap) tick();
        bus.rx_data_i  = b;
        bus.rx_valid_i = 1'b1;
        tick();
        bus.rx_valid_i = 1'b0;
    endtask

    task automatic build(input int seed, output logic [FW-1:0] f);
        for (int i = 0; i < NB; i++)
            f[8*i +: 8] = 8'((i * 7 + seed * 31 + (i >> 3)) & 255);
    endtask

    task automatic send_bytes(input logic [FW-1:0] f, input int from, input int upto);
        for (int i = from; i < upto; i++) begin
            if (i == NB - 1) check("pre_last_valid", bus.frame_valid_o, 0);
            send_byte(f[8*i +: 8], 0);
        end
    endtask

    task automatic expect_frame(input string tag);
        logic [FW-1:0] e;
        check({tag, "_valid"}, bus.frame_valid_o, 1);
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
        check({tag, "_frame"}, bus.frame_o, e);
    endtask

    task automatic handshake(input string tag);
        bus.frame_ready_i = 1'b1;
        tick();
        bus.frame_ready_i = 1'b0;
        check({tag, "_hs_valid"}, bus.frame_valid_o, 0);
        check({tag, "_hs_busy"}, bus.busy_o, 0);
    endtask

    initial begin
        logic [FW-1:0] f;
        logic [FW-1:0] g;
        int ov0;
        int to0;
        int held_bad;

        bus.rx_data_i     = 8'h00;
        bus.rx_valid_i    = 1'b0;
        bus.frame_ready_i = 1'b0;

        // Reset state
        rst_n = 1'b0;
        tick(); tick();
        check("rst_frame", bus.frame_o, 0);
        check("rst_valid", bus.frame_valid_o, 0);
        check("rst_busy", bus.busy_o, 0);
        check("rst_errs", {bus.err_timeout_o, bus.err_overrun_o}, 0);
        rst_n = 1'b1;
        tick();

        // Full frame with the reference leading bytes
        build(1, f);
        f[47:0] = 48'h37F9_AD00_3E01;
        exp_q.push_back(f);
        check("idle_busy", bus.busy_o, 0);
        send_byte(f[7:0], 0);
        check("busy_after_b0", bus.busy_o, 1);
        send_bytes(f, 1, NB);
        expect_frame("full");
        check("word0", bus.frame_o[15:0], 16'h3E01);
        check("word1", bus.frame_o[31:16], 16'hAD00);
        check("word2", bus.frame_o[47:32], 16'h37F9);

        // Backpressure: 500 cycles without ready, three dropped bytes
        ov0 = ov_cnt;
        held_bad = 0;
        for (int c = 0; c < 500; c++) begin
            if (c == 100 || c == 200 || c == 300) begin
                bus.rx_data_i  = 8'h55;
                bus.rx_valid_i = 1'b1;
            end
            tick();
            bus.rx_valid_i = 1'b0;
            if (c == 100) check("ovr_pulse", bus.err_overrun_o, 1);
            if (bus.frame_valid_o !== 1'b1 || bus.frame_o !== f) held_bad++;
        end
        tick();
        check("bp_held", held_bad, 0);
        check("bp_frame", bus.frame_o, f);
        check("bp_ovr_count", ov_cnt - ov0, 3);
        handshake("bp");

        // Back-to-back: next frame's byte 0 arrives on the handshake cycle
        build(2, f);
        exp_q.push_back(f);
        send_bytes(f, 0, NB);
        expect_frame("b2b_first");
        build(3, g);
        g[7:0] = 8'hAA;
        exp_q.push_back(g);
        ov0 = ov_cnt;
        bus.frame_ready_i = 1'b1;
        bus.rx_data_i     = 8'hAA;
        bus.rx_valid_i    = 1'b1;
        tick();
        bus.frame_ready_i = 1'b0;
        bus.rx_valid_i    = 1'b0;
        check("b2b_valid_drop", bus.frame_valid_o, 0);
        check("b2b_busy", bus.busy_o, 1);
        send_bytes(g, 1, NB);
        expect_frame("b2b_second");
        check("b2b_byte0", bus.frame_o[7:0], 8'hAA);
        check("b2b_no_ovr", ov_cnt - ov0, 0);
        handshake("b2b");

        // Timeout after 10 bytes, then a clean frame from index 0
        build(4, f);
        send_bytes(f, 0, 10);
        to0 = to_cnt;
        repeat (TIMEOUT_CLKS - 1) tick();
        check("to_not_yet_busy", bus.busy_o, 1);
        check("to_not_yet_pulse", bus.err_timeout_o, 0);
        tick();
        check("to_pulse", bus.err_timeout_o, 1);
        check("to_busy_low", bus.busy_o, 0);
        repeat (5) tick();
        check("to_single", to_cnt - to0, 1);
        build(5, f);
        exp_q.push_back(f);
        send_bytes(f, 0, NB);
        expect_frame("after_to");
        handshake("after_to");

        // Reset mid-frame discards it without error pulses
        build(6, f);
        send_bytes(f, 0, 50);
        to0 = to_cnt;
        ov0 = ov_cnt;
        rst_n = 1'b0;
        tick();
        check("mr_frame", bus.frame_o, 0);
        check("mr_valid", bus.frame_valid_o, 0);
        check("mr_busy", bus.busy_o, 0);
        check("mr_errs", {bus.err_timeout_o, bus.err_overrun_o}, 0);
        rst_n = 1'b1;
        tick();
        build(7, f);
        exp_q.push_back(f);
        send_bytes(f, 0, NB);
        expect_frame("after_rst");
        check("mr_no_pulses", (to_cnt - to0) + (ov_cnt - ov0), 0);
        handshake("after_rst");

        // Timeout boundary: gaps of TIMEOUT_CLKS-1 and TIMEOUT_CLKS clocks between strobes
        build(8, f);
        exp_q.push_back(f);
        to0 = to_cnt;
        send_byte(f[7:0], 0);
        send_byte(f[15:8], TIMEOUT_CLKS - 2);
        send_byte(f[23:16], TIMEOUT_CLKS - 1);
        check("tb_busy", bus.busy_o, 1);
        send_bytes(f, 3, NB);
        expect_frame("boundary");
        check("tb_no_timeout", to_cnt - to0, 0);
        handshake("boundary");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/rx_frame_assembler.md
RX_FRAME_ASSEMBLER -- requirements
Module: rx_frame_assembler

Interface
REQ-001 SHALL have parameter N_WORDS, default 64: Q6.10 words per frame; bytes per frame = 2*N_WORDS = 128.
REQ-002 SHALL have parameter TIMEOUT_CLKS, default 2000: idle clocks allowed between bytes of a partial frame (20 bit times at 100 clk/bit).
REQ-003 SHALL have port clk  input  1  sole clock; all logic on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port rx_data_i  input  8  received UART byte.
REQ-006 SHALL have port rx_valid_i  input  1  one-cycle strobe, rx_data_i valid.
REQ-007 SHALL have port frame_o  output  16*N_WORDS  assembled frame; word k at [16k +: 16].
REQ-008 SHALL have port frame_valid_o  output  1  frame_o complete and stable.
REQ-009 SHALL have port frame_ready_i  input  1  downstream softmax core accepts frame.
REQ-010 SHALL have port busy_o  output  1  high in COLLECT or FULL.
REQ-011 SHALL have port err_timeout_o  output  1  one-cycle pulse, partial frame discarded.
REQ-012 SHALL have port err_overrun_o  output  1  one-cycle pulse, byte dropped.

Function
REQ-013 SHALL implement states IDLE, COLLECT, FULL.
REQ-014 SHALL keep a byte index 0..2*N_WORDS-1; byte i is written to frame_o[8i +: 8], so word k = {byte[2k+1], byte[2k]} (little-endian).
REQ-015 IDLE: on rx_valid_i, SHALL store the byte at index 0, set index to 1, and go to COLLECT.
REQ-016 COLLECT: on rx_valid_i, SHALL store the byte at the current index and increment the index.
REQ-017 When the stored byte is index 2*N_WORDS-1, SHALL go to FULL, with frame_valid_o high on the next cycle (1-cycle latency from the last strobe).
REQ-018 FULL: SHALL hold frame_valid_o high and frame_o unchanged until frame_valid_o && frame_ready_i.
REQ-019 On handshake, SHALL drop frame_valid_o the next cycle, clear the index, and go to IDLE.
REQ-020 FULL without handshake: a rx_valid_i byte SHALL be dropped, err_overrun_o SHALL pulse next cycle, and frame_o SHALL be unchanged.
REQ-021 FULL with handshake and rx_valid_i in the same cycle: SHALL complete the handshake and store the byte as index 0 of the next frame, going to COLLECT with no overrun.
REQ-022 SHALL keep an idle counter in COLLECT, cleared on each rx_valid_i and incremented otherwise.
REQ-023 When the idle counter reaches TIMEOUT_CLKS-1 with no strobe, SHALL clear the index, go to IDLE, and pulse err_timeout_o next cycle.
REQ-024 SHALL leave stale frame_o bytes in place on timeout; frame_o content is valid only while frame_valid_o is high.
REQ-025 A strobe in the same cycle as the timeout limit SHALL count as a byte, with no timeout.
REQ-026 frame_ready_i SHALL be ignored outside FULL.
REQ-027 SHALL have no combinational path from any input to any output; all outputs registered.
REQ-028 busy_o SHALL be high in COLLECT and FULL, low in IDLE.

Reset
REQ-029 With rst_n low at a clock edge, SHALL return to IDLE and clear the index and idle counter.
REQ-030 During reset, SHALL drive frame_valid_o, busy_o, err_timeout_o and err_overrun_o to 0 and frame_o to all zeros.
REQ-031 Reset mid-COLLECT or mid-FULL SHALL discard the frame, with no pulse on either error output.
REQ-032 The first strobe after rst_n rises SHALL be byte index 0.

Verification
REQ-033 Full frame: 128 strobes with bytes 01,3E,00,AD,F9,37,... -> frame_valid_o 1 cycle after the last strobe; frame_o[15:0]=16'h3E01, [31:16]=16'hAD00, [47:32]=16'h37F9; busy_o high from cycle after byte 0.
REQ-034 Backpressure: frame_ready_i low 500 cycles after full, 3 strobes during this -> frame_valid_o held, frame_o unchanged, 3 err_overrun_o pulses; ready high -> valid low next cycle, state IDLE.
REQ-035 Back-to-back: rx_valid_i=1 with byte 0xAA in the handshake cycle -> no overrun; next frame_o[7:0]=8'hAA after its completion.
REQ-036 Timeout: 10 bytes, then silence TIMEOUT_CLKS cycles -> single err_timeout_o pulse, busy_o low; next 128 bytes form a clean frame starting at index 0.
REQ-037 Reset mid-frame: 50 bytes, rst_n low 1 cycle -> all outputs 0 and no error pulses; 128 new bytes -> correct frame.
REQ-038 Timeout boundary: a strobe exactly TIMEOUT_CLKS-1 cycles after the prior byte -> accepted, no err_timeout_o.
